us64_rep: RTL and testbench

- Inverse of the 64:1 (8x8) block downsampler: nearest-neighbour upscaler for one 8-bit colour channel.
- Accepts a downsampled raster one input row at a time into a line buffer.
- Replays each stored pixel FACTOR times horizontally and each row FACTOR times vertically, so a 32x32 frame is restored to a 256x256 stream (65536 beats).
- Three instances (R, G, B) sit between RGB_separate output of the low-res store and RGB_compress feeding the display or capture path.

---
 rtl/us_pkg.sv | 26 ++
 rtl/us_line_buf.sv | 26 ++
 rtl/us64_rep.sv | 135 +++++++++++++
 tb/tb_us64_rep.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/us_pkg.sv
// Shared types, defaults and width helpers for the nearest-neighbour upscaler.
package us_pkg;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } us_state_e;

  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned IN_W_DEF   = 32;
  localparam int unsigned IN_H_DEF   = 32;
  localparam int unsigned FACTOR_DEF = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Counter width: never narrower than one bit, even for a single-entry range.
  function automatic int unsigned cw(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/us_line_buf.sv
// One-row pixel store: synchronous write, asynchronous read.
module us_line_buf
  import us_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = IN_W_DEF,
  parameter int unsigned AW    = cw(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/us64_rep.sv
// Nearest-neighbour upscaler: buffers one input row, then replays each pixel
// FACTOR times across and the whole row FACTOR times down.
module us64_rep
  import us_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned IN_H   = IN_H_DEF,
  parameter int unsigned FACTOR = FACTOR_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          sof,
  output logic          eol,
  output logic          eof
);

  localparam int unsigned OUT_W = IN_W * FACTOR;
  localparam int unsigned XW    = cw(IN_W);
  localparam int unsigned OW    = cw(OUT_W);
  localparam int unsigned RW    = cw(FACTOR);
  localparam int unsigned YW    = cw(IN_H);
  localparam int unsigned SH    = clog2(FACTOR);

  localparam logic [XW-1:0] WR_LAST  = XW'(IN_W - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_W - 1);
  localparam logic [RW-1:0] R_LAST   = RW'(FACTOR - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IN_H - 1);

  us_state_e     state_q;
  logic [XW-1:0] wr_x_q;
  logic [OW-1:0] out_x_q;
  logic [RW-1:0] r_q;
  logic [YW-1:0] y_q;
  logic [DW-1:0] dout_q;
  logic          dout_valid_q;
  logic          sof_q;
  logic          eol_q;
  logic          eof_q;

  logic          wr_en;
  logic [XW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          slot_free;
  logic          line_end;
  logic          r_last;
  logic          y_last;

  assign din_ready = (state_q == FILL);
  assign wr_en     = din_valid && din_ready;
  assign rd_addr   = XW'(out_x_q >> SH);
  assign slot_free = !dout_valid_q || dout_ready;
  assign line_end  = (out_x_q == OUT_LAST);
  assign r_last    = (r_q == R_LAST);
  assign y_last    = (y_q == Y_LAST);

  us_line_buf #(
    .DW   (DW),
    .DEPTH(IN_W),
    .AW   (XW)
  ) u_line_buf (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_x_q),
    .wdata(din),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  // Fill/emit sequencer with the output register; refill may start while the
  // last replayed beat is still held, since that pixel is already registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      wr_x_q       <= '0;
      out_x_q      <= '0;
      r_q          <= '0;
      y_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (dout_valid_q && dout_ready) dout_valid_q <= 1'b0;
          if (wr_en) begin
            if (wr_x_q == WR_LAST) begin
              wr_x_q  <= '0;
              state_q <= EMIT;
            end else begin
              wr_x_q <= wr_x_q + XW'(1);
            end
          end
        end
        EMIT: begin
          if (slot_free) begin
            dout_q       <= rd_data;
            dout_valid_q <= 1'b1;
            sof_q        <= (y_q == '0) && (r_q == '0) && (out_x_q == '0);
            eol_q        <= line_end;
            eof_q        <= line_end && r_last && y_last;
            if (line_end) begin
              out_x_q <= '0;
              if (r_last) begin
                r_q     <= '0;
                y_q     <= y_last ? '0 : y_q + YW'(1);
                state_q <= FILL;
              end else begin
                r_q <= r_q + RW'(1);
              end
            end else begin
              out_x_q <= out_x_q + OW'(1);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sof        = sof_q;
  assign eol        = eol_q;
  assign eof        = eof_q;

endmodule

// File: tb/tb_us64_rep.sv
// Scoreboard bench for us64_rep: default-size instance plus a 4-wide, 2x, 2-row instance.
module tb_us64_rep;
  import us_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       sof, eol, eof;

  logic [7:0] s_din;
  logic       s_din_valid;
  logic       s_din_ready;
  logic [7:0] s_dout;
  logic       s_dout_valid;
  logic       s_dout_ready;
  logic       s_sof, s_eol, s_eof;

  us64_rep dut (
    .clk(clk), .rst_n(rst_n),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .sof(sof), .eol(eol), .eof(eof)
  );

  us64_rep #(.DW(8), .IN_W(4), .IN_H(2), .FACTOR(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .din(s_din), .din_valid(s_din_valid), .din_ready(s_din_ready),
    .dout(s_dout), .dout_valid(s_dout_valid), .dout_ready(s_dout_ready),
    .sof(s_sof), .eol(s_eol), .eof(s_eof)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  beat_t q[$];
  beat_t sq[$];
  int    pops = 0;
  bit    held = 1'b0;
  logic [10:0] saved;
  bit    rand_rdy = 1'b0;

  function automatic logic [7:0] pix(input int row, input int col);
    return 8'((row * 32 + col) % 256);
  endfunction

  // Ready pattern changes just after each rising edge.
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dout_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Default-instance monitor: stall stability plus in-order beat compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) chk("stall hold", {21'd0, dout, sof, eol, eof}, {21'd0, saved});
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) begin
          chk("unexpected beat", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("dout", {24'd0, dout}, {24'd0, e.d});
          chk("sof", {31'd0, sof}, {31'd0, e.sof});
          chk("eol", {31'd0, eol}, {31'd0, e.eol});
          chk("eof", {31'd0, eof}, {31'd0, e.eof});
        end
        pops++;
      end
      held  = dout_valid && !dout_ready;
      saved = {dout, sof, eol, eof};
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_dout_valid && s_dout_ready) begin
      if (sq.size() == 0) begin
        chk("small unexpected beat", 32'd1, 32'd0);
      end else begin
        beat_t e;
        e = sq.pop_front();
        chk("small dout", {24'd0, s_dout}, {24'd0, e.d});
        chk("small sof", {31'd0, s_sof}, {31'd0, e.sof});
        chk("small eol", {31'd0, s_eol}, {31'd0, e.eol});
        chk("small eof", {31'd0, s_eof}, {31'd0, e.eof});
      end
    end
  end

  task automatic push_row(input int row);
    beat_t b;
    for (int r = 0; r < 8; r++) begin
      for (int x = 0; x < 256; x++) begin
        b.d   = pix(row, x / 8);
        b.sof = (row == 0) && (r == 0) && (x == 0);
        b.eol = (x == 255);
        b.eof = (row == 31) && (r == 7) && (x == 255);
        q.push_back(b);
      end
    end
  endtask

  // Called and returns at posedge+1.
  task automatic feed_row(input int row, input bit hold_ff, input bit chk_lat);
    int guard;
    guard = 0;
    while (din_ready !== 1'b1) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 5000) begin
        chk("fill wait timeout", 32'd0, 32'd1);
        return;
      end
    end
    for (int c = 0; c < 32; c++) begin
      din_valid = 1'b1;
      din       = pix(row, c);
      @(posedge clk);
      #1;
    end
    push_row(row);
    din_valid = hold_ff;
    din       = hold_ff ? 8'hFF : 8'h00;
    if (chk_lat) begin
      chk("din_ready in EMIT", {31'd0, din_ready}, 32'd0);
      chk("dout_valid before first beat", {31'd0, dout_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("first beat latency", {31'd0, dout_valid}, 32'd1);
    end
    if (hold_ff) begin
      guard = 0;
      while (din_ready !== 1'b1 && guard < 5000) begin
        @(posedge clk);
        #1;
        guard++;
      end
      chk("hold row end", {31'd0, din_ready}, 32'd1);
      din_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q.size() != 0 || sq.size() != 0) && guard < 10000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain big queue", q.size(), 32'd0);
    chk("drain small queue", sq.size(), 32'd0);
  endtask

  // Small instance: rows A1..D4 and 11..44, each pixel doubled, each row doubled.
  initial begin
    logic [7:0] sp [2][4];
    beat_t      b;
    int         guard;
    sp = '{'{8'hA1, 8'hB2, 8'hC3, 8'hD4}, '{8'h11, 8'h22, 8'h33, 8'h44}};
    s_din_valid  = 1'b0;
    s_din        = 8'h00;
    s_dout_ready = 1'b1;
    @(posedge rst_n);
    @(posedge clk);
    #1;
    for (int row = 0; row < 2; row++) begin
      guard = 0;
      while (s_din_ready !== 1'b1 && guard < 100) begin
        @(posedge clk);
        #1;
        guard++;
      end
      for (int c = 0; c < 4; c++) begin
        s_din_valid = 1'b1;
        s_din       = sp[row][c];
        @(posedge clk);
        #1;
      end
      s_din_valid = 1'b0;
      for (int r = 0; r < 2; r++) begin
        for (int x = 0; x < 8; x++) begin
          b.d   = sp[row][x / 2];
          b.sof = (row == 0) && (r == 0) && (x == 0);
          b.eol = (x == 7);
          b.eof = (row == 1) && (r == 1) && (x == 7);
          sq.push_back(b);
        end
      end
    end
  end

  initial begin
    int guard;
    din       = 8'h00;
    din_valid = 1'b0;
    #1;
    chk("reset dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("reset dout", {24'd0, dout}, 32'd0);
    chk("reset flags", {29'd0, sof, eol, eof}, 32'd0);
    chk("reset din_ready", {31'd0, din_ready}, 32'd1);
    chk("reset small dout_valid", {31'd0, s_dout_valid}, 32'd0);
    #21;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    feed_row(0, 1'b1, 1'b1);
    drain();
    rand_rdy = 1'b1;
    feed_row(1, 1'b0, 1'b1);
    drain();
    rand_rdy = 1'b0;
    feed_row(2, 1'b0, 1'b1);
    feed_row(3, 1'b0, 1'b1);

    guard = 0;
    while (pops < 3 * 2048 + 100 && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("reach row3 beat 100", pops, 32'(3 * 2048 + 100));
    rst_n = 1'b0;
    #1;
    chk("mid reset dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("mid reset din_ready", {31'd0, din_ready}, 32'd1);
    q.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post reset din_ready", {31'd0, din_ready}, 32'd1);
    chk("post reset dout_valid", {31'd0, dout_valid}, 32'd0);

    for (int row = 0; row < 32; row++) feed_row(row, 1'b0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
